// File: rtl/karnaugh_sweep_ctrl.sv
// karnaugh_sweep_ctrl
// -------------------
// Exhaustive self-test sequencer for the 4-input Karnaugh-simplified function
// block. It walks A3..A0 through all 16 input combinations, holds each one for
// SETTLE cycles, samples Z on the following cycle, and compares every sample
// against the EXPECTED truth table. The captured table, the mismatch count,
// the first failing index and an overall pass flag are reported through a
// start/busy/done handshake.
//
// Parameters:
//   EXPECTED      expected Z per index; bit k is Z for {A3,A2,A1,A0}=k
//   SETTLE        cycles each vector is held before its sample cycle (1..15)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   start         request a sweep (only looked at while idle)
//   abort         synchronous cancel of a running sweep
//   Z             output of the function block under test
//   A0..A3        function inputs; {A3,A2,A1,A0} is the current index
//   busy          sweep in progress
//   done          one-cycle completion pulse
//   pass          last completed sweep had zero mismatches
//   err_count     mismatches in the current/last sweep (0..16)
//   err_valid     at least one mismatch has been recorded
//   first_err_idx index of the first mismatch (meaningful when err_valid=1)
//   truth_table   captured Z values; bit k = Z sampled at index k

module karnaugh_sweep_ctrl #(
    parameter logic [15:0] EXPECTED = 16'h6996,
    parameter int          SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        Z,
    output logic        A0,
    output logic        A1,
    output logic        A2,
    output logic        A3,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic        err_valid,
    output logic [3:0]  first_err_idx,
    output logic [15:0] truth_table
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic [4:0] err_next;

    // The function inputs are driven straight from the index register so the
    // block under test always sees a glitch-free, registered vector.
    assign A0 = idx[0];
    assign A1 = idx[1];
    assign A2 = idx[2];
    assign A3 = idx[3];

    // Comparison of the live Z against the expected bit for the current
    // index. err_next is the count as it would stand after this sample, so
    // the final pass decision can include the last comparison in the same
    // edge that enters FINISH. Sixteen mismatches fit in five bits, so the
    // count can never wrap.
    always_comb begin
        mismatch = (Z != EXPECTED[idx]);
        err_next = err_count + 5'(mismatch);
    end

    // Main sequencer. Every output is a register updated here. Abort wins
    // over the sample update at the same edge, leaving partial results
    // intact but forcing pass low and suppressing the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= 4'd0;
            settle_cnt    <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 5'd0;
            err_valid     <= 1'b0;
            first_err_idx <= 4'd0;
            truth_table   <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx           <= 4'd0;
                        settle_cnt    <= 4'd0;
                        err_count     <= 5'd0;
                        err_valid     <= 1'b0;
                        first_err_idx <= 4'd0;
                        truth_table   <= 16'd0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        pass       <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        pass       <= 1'b0;
                    end else begin
                        truth_table[idx] <= Z;
                        if (mismatch) begin
                            err_count <= err_next;
                            if (!err_valid) begin
                                first_err_idx <= idx;
                                err_valid     <= 1'b1;
                            end
                        end
                        if (idx == 4'd15) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            pass  <= (err_next == 5'd0);
                        end else begin
                            idx        <= idx + 4'd1;
                            settle_cnt <= 4'd0;
                            state      <= ST_SETTLE;
                        end
                    end
                end

                ST_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= 4'd0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    idx   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karnaugh_sweep_ctrl.sv
// tb_karnaugh_sweep_ctrl
// ----------------------
// Directed bench for karnaugh_sweep_ctrl. dut1 uses SETTLE=2 and a Z model
// that can be a faithful function block, a faulted one, or stuck at 0/1.
// dut2 uses SETTLE=1 with a faithful Z model.

module tb_karnaugh_sweep_ctrl;

    localparam logic [15:0] EXP = 16'h6996;

    logic clk;
    logic rst;

    logic        d1_start, d1_abort, d1_z;
    logic        d1_a0, d1_a1, d1_a2, d1_a3;
    logic        d1_busy, d1_done, d1_pass, d1_err_valid;
    logic [4:0]  d1_err_count;
    logic [3:0]  d1_first_err;
    logic [15:0] d1_tt;
    logic [3:0]  d1_idx;

    logic        d2_start, d2_abort, d2_z;
    logic        d2_a0, d2_a1, d2_a2, d2_a3;
    logic        d2_busy, d2_done, d2_pass, d2_err_valid;
    logic [4:0]  d2_err_count;
    logic [3:0]  d2_first_err;
    logic [15:0] d2_tt;
    logic [3:0]  d2_idx;

    logic [1:0]  z_mode;
    logic [15:0] fault_mask;

    int checks;
    int failures;

    assign d1_idx = {d1_a3, d1_a2, d1_a1, d1_a0};
    assign d2_idx = {d2_a3, d2_a2, d2_a1, d2_a0};

    // z_mode 0: function block model (optionally faulted), 1: stuck 0, 2: stuck 1
    assign d1_z = (z_mode == 2'd1) ? 1'b0 :
                  (z_mode == 2'd2) ? 1'b1 :
                  (EXP[d1_idx] ^ fault_mask[d1_idx]);
    assign d2_z = EXP[d2_idx];

    karnaugh_sweep_ctrl #(.EXPECTED(EXP), .SETTLE(2)) dut1 (
        .clk(clk), .rst(rst), .start(d1_start), .abort(d1_abort), .Z(d1_z),
        .A0(d1_a0), .A1(d1_a1), .A2(d1_a2), .A3(d1_a3),
        .busy(d1_busy), .done(d1_done), .pass(d1_pass),
        .err_count(d1_err_count), .err_valid(d1_err_valid),
        .first_err_idx(d1_first_err), .truth_table(d1_tt)
    );

    karnaugh_sweep_ctrl #(.EXPECTED(EXP), .SETTLE(1)) dut2 (
        .clk(clk), .rst(rst), .start(d2_start), .abort(d2_abort), .Z(d2_z),
        .A0(d2_a0), .A1(d2_a1), .A2(d2_a2), .A3(d2_a3),
        .busy(d2_busy), .done(d2_done), .pass(d2_pass),
        .err_count(d2_err_count), .err_valid(d2_err_valid),
        .first_err_idx(d2_first_err), .truth_table(d2_tt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns just after the accepting edge E0
    task automatic pulse_start1();
        tick();
        d1_start = 1'b1;
        tick();
        d1_start = 1'b0;
    endtask

    task automatic pulse_start2();
        tick();
        d2_start = 1'b1;
        tick();
        d2_start = 1'b0;
    endtask

    // Wait for dut1 done with a cycle budget; done_edge counts edges after E0
    task automatic wait_done1(output int done_edge);
        int n;
        n = 0;
        while (!d1_done && n < 200) begin
            tick();
            n++;
        end
        done_edge = n;
        checks++;
        if (!d1_done) begin
            failures++;
            $display("[TB] FAIL wait_done1 timeout: done=%0b after %0d cycles, required 1", d1_done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({d1_busy, d1_done, d1_pass, d1_err_count, d1_err_valid, d1_first_err, d1_tt, d1_idx} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL reset_dut1 got busy=%0b done=%0b pass=%0b err=%0d tt=%h idx=%0d, required all 0",
                     d1_busy, d1_done, d1_pass, d1_err_count, d1_tt, d1_idx);
        end
        checks++;
        if ({d2_busy, d2_done, d2_pass, d2_err_count, d2_err_valid, d2_first_err, d2_tt, d2_idx} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL reset_dut2 got busy=%0b done=%0b pass=%0b err=%0d tt=%h idx=%0d, required all 0",
                     d2_busy, d2_done, d2_pass, d2_err_count, d2_tt, d2_idx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        int bad;
        z_mode = 2'd0;
        fault_mask = 16'd0;
        pulse_start1();
        bad = 0;
        for (int n = 0; n < 48; n++) begin
            if (n > 0) tick();
            if (d1_idx !== 4'(n / 3) || d1_busy !== 1'b1 || d1_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL clean_step n=%0d idx=%0d busy=%0b done=%0b, required idx=%0d busy=1 done=0",
                         n, d1_idx, d1_busy, d1_done, n / 3);
            end
        end
        checks++;
        if (bad != 0) failures++;
        tick();
        checks++;
        if (d1_done !== 1'b1 || d1_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_done_E48 done=%0b busy=%0b, required 1 1", d1_done, d1_busy);
        end
        checks++;
        if (d1_pass !== 1'b1 || d1_err_count !== 5'd0 || d1_err_valid !== 1'b0 || d1_tt !== 16'h6996) begin
            failures++;
            $display("[TB] FAIL clean_results pass=%0b err=%0d valid=%0b tt=%h, required 1 0 0 6996",
                     d1_pass, d1_err_count, d1_err_valid, d1_tt);
        end
        tick();
        checks++;
        if (d1_done !== 1'b0 || d1_busy !== 1'b0 || d1_idx !== 4'd0) begin
            failures++;
            $display("[TB] FAIL clean_idle_E49 done=%0b busy=%0b idx=%0d, required 0 0 0", d1_done, d1_busy, d1_idx);
        end
    endtask

    task automatic test_fault_model();
        int de;
        z_mode = 2'd0;
        fault_mask = 16'h0240;
        pulse_start1();
        wait_done1(de);
        checks++;
        if (de != 48) begin
            failures++;
            $display("[TB] FAIL fault_done_edge got %0d, required 48", de);
        end
        checks++;
        if (d1_tt !== 16'h6bd6 || d1_err_count !== 5'd2 || d1_err_valid !== 1'b1 ||
            d1_first_err !== 4'd6 || d1_pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fault_results tt=%h err=%0d valid=%0b first=%0d pass=%0b, required 6bd6 2 1 6 0",
                     d1_tt, d1_err_count, d1_err_valid, d1_first_err, d1_pass);
        end
        tick();
        fault_mask = 16'd0;
    endtask

    task automatic test_stuck();
        int de;
        z_mode = 2'd1;
        pulse_start1();
        wait_done1(de);
        checks++;
        if (d1_tt !== 16'h0000 || d1_err_count !== 5'd8 || d1_err_valid !== 1'b1 ||
            d1_first_err !== 4'd1 || d1_pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stuck0_results tt=%h err=%0d valid=%0b first=%0d pass=%0b, required 0000 8 1 1 0",
                     d1_tt, d1_err_count, d1_err_valid, d1_first_err, d1_pass);
        end
        tick();
        z_mode = 2'd2;
        pulse_start1();
        wait_done1(de);
        checks++;
        if (d1_tt !== 16'hffff || d1_err_count !== 5'd8 || d1_err_valid !== 1'b1 ||
            d1_first_err !== 4'd0 || d1_pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stuck1_results tt=%h err=%0d valid=%0b first=%0d pass=%0b, required ffff 8 1 0 0",
                     d1_tt, d1_err_count, d1_err_valid, d1_first_err, d1_pass);
        end
        tick();
        z_mode = 2'd0;
    endtask

    task automatic test_abort();
        int de;
        int done_seen;
        z_mode = 2'd0;
        fault_mask = 16'h0040;
        pulse_start1();
        for (int n = 0; n < 20; n++) tick();
        checks++;
        if (d1_idx !== 4'd6 || d1_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_pre idx=%0d busy=%0b, required 6 1", d1_idx, d1_busy);
        end
        d1_abort = 1'b1;
        tick();
        d1_abort = 1'b0;
        checks++;
        if (d1_busy !== 1'b0 || d1_done !== 1'b0 || d1_pass !== 1'b0 || d1_idx !== 4'd0) begin
            failures++;
            $display("[TB] FAIL abort_state busy=%0b done=%0b pass=%0b idx=%0d, required 0 0 0 0",
                     d1_busy, d1_done, d1_pass, d1_idx);
        end
        checks++;
        if (d1_tt !== 16'h0016 || d1_err_count !== 5'd0 || d1_err_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_partial tt=%h err=%0d valid=%0b, required 0016 0 0",
                     d1_tt, d1_err_count, d1_err_valid);
        end
        done_seen = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (d1_done || d1_busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("[TB] FAIL abort_quiet active_cycles=%0d, required 0", done_seen);
        end
        fault_mask = 16'd0;
        pulse_start1();
        wait_done1(de);
        checks++;
        if (d1_pass !== 1'b1 || d1_tt !== 16'h6996 || d1_err_count !== 5'd0) begin
            failures++;
            $display("[TB] FAIL abort_rerun pass=%0b tt=%h err=%0d, required 1 6996 0", d1_pass, d1_tt, d1_err_count);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int done_seen;
        z_mode = 2'd0;
        pulse_start1();
        for (int n = 0; n < 28; n++) tick();
        checks++;
        if (d1_idx !== 4'd9 || d1_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL areset_pre idx=%0d busy=%0b, required 9 1", d1_idx, d1_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({d1_busy, d1_done, d1_pass, d1_err_count, d1_err_valid, d1_first_err, d1_tt, d1_idx} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL areset_immediate busy=%0b tt=%h idx=%0d err=%0d, required all 0",
                     d1_busy, d1_tt, d1_idx, d1_err_count);
        end
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (d1_done || d1_busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("[TB] FAIL areset_quiet active_cycles=%0d, required 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        int de;
        int gaps[3];
        z_mode = 2'd0;
        tick();
        d1_start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wait_done1(de);
            gaps[s] = de;
            checks++;
            if (d1_pass !== 1'b1 || d1_tt !== 16'h6996 || d1_err_count !== 5'd0 || d1_err_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_results sweep=%0d pass=%0b tt=%h err=%0d, required 1 6996 0",
                         s, d1_pass, d1_tt, d1_err_count);
            end
            if (s == 2) d1_start = 1'b0;
            tick();
            checks++;
            if (d1_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_pulse_width sweep=%0d done=%0b, required 0", s, d1_done);
            end
        end
        checks++;
        if (gaps[1] != gaps[2]) begin
            failures++;
            $display("[TB] FAIL b2b_period got %0d then %0d, required equal", gaps[1], gaps[2]);
        end
        tick();
        tick();
        checks++;
        if (d1_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stop busy=%0b, required 0", d1_busy);
        end
    endtask

    task automatic test_settle1();
        int bad;
        pulse_start2();
        bad = 0;
        for (int n = 0; n < 32; n++) begin
            if (n > 0) tick();
            if (n == 10) d2_start = 1'b1;
            if (n == 11) d2_start = 1'b0;
            if (d2_idx !== 4'(n / 2) || d2_busy !== 1'b1 || d2_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL s1_step n=%0d idx=%0d busy=%0b done=%0b, required idx=%0d busy=1 done=0",
                         n, d2_idx, d2_busy, d2_done, n / 2);
            end
        end
        checks++;
        if (bad != 0) failures++;
        tick();
        checks++;
        if (d2_done !== 1'b1 || d2_pass !== 1'b1 || d2_tt !== 16'h6996 || d2_err_count !== 5'd0 || d2_err_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL s1_done_E32 done=%0b pass=%0b tt=%h err=%0d valid=%0b, required 1 1 6996 0 0",
                     d2_done, d2_pass, d2_tt, d2_err_count, d2_err_valid);
        end
        tick();
        checks++;
        if (d2_done !== 1'b0 || d2_busy !== 1'b0 || d2_idx !== 4'd0) begin
            failures++;
            $display("[TB] FAIL s1_idle_E33 done=%0b busy=%0b idx=%0d, required 0 0 0", d2_done, d2_busy, d2_idx);
        end
        tick();
        tick();
        checks++;
        if (d2_busy !== 1'b0 || d2_pass !== 1'b1) begin
            failures++;
            $display("[TB] FAIL s1_start_while_busy busy=%0b pass=%0b, required 0 1", d2_busy, d2_pass);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        d1_start   = 1'b0;
        d1_abort   = 1'b0;
        d2_start   = 1'b0;
        d2_abort   = 1'b0;
        z_mode     = 2'd0;
        fault_mask = 16'd0;
        $display("[TB] starting karnaugh_sweep_ctrl bench");
        test_reset();
        test_clean_sweep();
        test_fault_model();
        test_stuck();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_settle1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
